// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle for sync_fifo_prog: write port, read port, thresholds and flags.
// The FIFO connects through the slave modport; the producer/consumer side uses master.
interface sync_fifo_prog_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [AW:0]           af_thresh;
    logic [AW:0]           ae_thresh;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_prog_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic [AW:0] count_c;
    logic        full_c;
    logic        empty_c;
    logic        wr_acc_c;
    logic        rd_acc_c;

    // Extra pointer MSB disambiguates full from empty; subtraction wraps naturally.
    always_comb begin
        count_c  = wr_ptr_q - rd_ptr_q;
        full_c   = (count_c == (AW+1)'(DEPTH));
        empty_c  = (count_c == '0);
        wr_acc_c = bus.wr_en & ~full_c;
        rd_acc_c = bus.rd_en & ~empty_c;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q & ~bus.err_clr;
        underflow_d = underflow_q & ~bus.err_clr;
        if (wr_acc_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_acc_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        // A new error in the same cycle as err_clr wins over the clear.
        if (bus.wr_en && full_c)  overflow_d  = 1'b1;
        if (bus.rd_en && empty_c) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.rd_valid = ~empty_c;
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc_c;
        if (rd_acc_c) rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.count        = count_c;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_c >= bus.af_thresh);
    assign bus.almost_empty = (count_c <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog (DEPTH=16, DATA_WIDTH=8, registered-read build).
module tb_sync_fifo_prog;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sync_fifo_prog_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.err_clr  = 1'b0;
        bus.af_thresh = 5'd16;
        bus.ae_thresh = 5'd2;
        #1;

        // Reset state
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        check("rst_almost_full", 32'(bus.almost_full), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_count", 32'(bus.count), 32'd0);
        check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Fill with 0x00..0x0F then read back in order
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_af_at_16", 32'(bus.almost_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            check("rd_valid", 32'(bus.rd_valid), 32'd1);
            check("rd_data", 32'(bus.rd_data), 32'(i));
        end
        bus.rd_en = 1'b0;
        tick();
        check("drain_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("drain_hold_data", 32'(bus.rd_data), 32'h0F);
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Overflow while full, then clear
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            tick();
        end
        bus.wr_data = 8'hAA;
        tick();
        bus.wr_en = 1'b0;
        check("ovf_count", 32'(bus.count), 32'd16);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        tick();
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            check("ovf_rd_data", 32'(bus.rd_data), 32'(8'h10 + i));
        end
        bus.rd_en = 1'b0;
        tick();
        check("ovf_empty", 32'(bus.empty), 32'd1);

        // Threshold behaviour: af=12, ae=3
        bus.af_thresh = 5'd12;
        bus.ae_thresh = 5'd3;
        #1;
        check("th_ae_at_0", 32'(bus.almost_empty), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h30 + i);
            tick();
            check("th_count", 32'(bus.count), 32'(i));
            check("th_almost_empty", 32'(bus.almost_empty), (i <= 3) ? 32'd1 : 32'd0);
            check("th_almost_full", 32'(bus.almost_full), (i >= 12) ? 32'd1 : 32'd0);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        check("th_af_drop_count", 32'(bus.count), 32'd11);
        check("th_af_drop", 32'(bus.almost_full), 32'd0);
        for (int i = 0; i < 11; i++) tick();
        bus.rd_en = 1'b0;
        check("th_drain_empty", 32'(bus.empty), 32'd1);
        check("th_last_data", 32'(bus.rd_data), 32'h3C);

        // Simultaneous write+read while empty: write wins, underflow set
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("we_count", 32'(bus.count), 32'd1);
        check("we_underflow", 32'(bus.underflow), 32'd1);
        check("we_rd_valid", 32'(bus.rd_valid), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("we_udf_cleared", 32'(bus.underflow), 32'd0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("we_rd_data", 32'(bus.rd_data), 32'h55);

        // Fill to 8 then stream 40 cycles of simultaneous write/read
        for (int i = 0; i < 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'b1;
            bus.wr_data = 8'(8 + k);
            tick();
            check("stream_count", 32'(bus.count), 32'd8);
            check("stream_rd_data", 32'(bus.rd_data), 32'(k));
            check("stream_flags", {30'd0, bus.full, bus.empty}, 32'd0);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_count", 32'(bus.count), 32'd5);
        check("pre_rst_rd_data", 32'(bus.rd_data), 32'd42);
        check("pre_rst_rd_valid", 32'(bus.rd_valid), 32'd1);

        // Asynchronous reset pulse between edges with 5 entries held
        bus.rd_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_empty", 32'(bus.empty), 32'd1);
        check("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        rst = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("arst_underflow", 32'(bus.underflow), 32'd1);
        check("arst_rd_valid_after", 32'(bus.rd_valid), 32'd0);
        check("arst_rd_data", 32'(bus.rd_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Parametrised synchronous FIFO that succeeds the existing single-clock FIFO.
- Adds the following over the existing block:
  - programmable almost-full and almost-empty thresholds
  - an occupancy count output
  - sticky overflow and underflow error flags
  - a registered read-valid strobe that replaces the tri-state data output
  - an optional first-word-fall-through mode
- Sits between producer and consumer datapaths in a single clock domain.

Parameters:
- DATA_WIDTH, 8: width of each data word in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AW, $clog2(DEPTH): pointer index width. Derived; do not override.

Ports:
- clk  input  1  the only clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (pop acknowledge when FWFT is enabled).
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  rd_data holds a newly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- af_thresh  input  AW+1  almost-full threshold.
- ae_thresh  input  AW+1  almost-empty threshold.
- almost_full  output  1  count >= af_thresh.
- almost_empty  output  1  count <= ae_thresh.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- err_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset (asynchronous, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - empty=1, full=0. almost_* are evaluated from count=0 against the thresholds.
  - Memory contents are not reset.
  - A reset asserted mid-operation discards all contents immediately. Outputs take their reset values without waiting for a clock edge.
- Pointers:
  - Width is AW+1; the extra MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
  - Memory is indexed by ptr[AW-1:0].
  - count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- full, empty, almost_full and almost_empty are combinational from the registered pointers and the threshold inputs.
- Accepted write (wr_en=1 and full=0):
  - mem[wr_ptr] <= wr_data; wr_ptr increments.
- Rejected write (wr_en=1 and full=1):
  - Data is dropped; overflow <= 1.
- Accepted read (rd_en=1 and empty=0), non-FWFT:
  - rd_data <= mem[rd_ptr] and rd_ptr increments on that edge.
  - rd_valid=1 for exactly the following cycle (latency 1).
- Rejected read (rd_en=1 and empty=1):
  - rd_data holds, rd_valid=0, underflow <= 1.
- When no read is accepted, rd_valid=0 and rd_data holds its last value.
- Simultaneous events: full and empty are the values at the start of the cycle.
  - Write and read while full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
  - Write and read while empty: write accepted, read rejected, underflow set, count becomes 1.
  - Write and read otherwise: both accepted; count unchanged.
- err_clr clears both sticky flags on the next edge. If a new error occurs in the same cycle, setting wins.
- Thresholds are compared unsigned. Threshold values above DEPTH are legal: almost_full then never asserts, and almost_empty is always asserted.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data always presents mem[rd_ptr]; rd_valid = !empty.
  - rd_en acts as a pop acknowledge: it advances rd_ptr with zero added latency.
  - After a write into an empty FIFO, the word appears on rd_data with rd_valid=1 one cycle after the write edge.
  - rd_en while empty sets underflow.
- Undefined: the standard 1-cycle registered read described above.

Test Plan (DEPTH=16, DATA_WIDTH=8):
- Reset then idle: count=0, empty=1, full=0, rd_valid=0, overflow=0, underflow=0, rd_data=0x00.
- Write 0x00..0x0F over 16 cycles, then read 16:
  - full=1 and count=16 after the 16th write.
  - Reads return 0x00..0x0F in order, each with rd_valid one cycle after rd_en.
  - empty=1 at the end.
- While full (16 entries), assert wr_en=1 with wr_data=0xAA:
  - count stays 16 and overflow=1.
  - Pulse err_clr: overflow=0.
  - Subsequent reads never return 0xAA.
- Set af_thresh=12 and ae_thresh=3, then write 12 words:
  - almost_empty deasserts when count reaches 4.
  - almost_full asserts when count reaches 12.
  - Read 1 word: almost_full deasserts at count 11.
- Fill to 8, then drive simultaneous wr_en and rd_en for 40 cycles with an incrementing pattern:
  - count stays 8 through pointer wrap-around.
  - Data order is preserved, with no spurious full or empty.
- Assert rst for 1 ns mid-stream with 5 entries held:
  - count=0, empty=1 and rd_valid=0 immediately, without a clock edge.
  - A read on the next cycle sets underflow=1.
